// File: rtl/leb128_i64_stream_dec_if.sv
// Byte-in / i64-out handshake bundle for the LEB128 stream decoder.
// slave = decoder side, master = source/sink side.
interface leb128_i64_stream_dec_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_data;
  logic [3:0]  out_len;
  logic        out_err;
  logic        out_valid;
  logic        out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_len,
    output out_err, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_len,
    input  out_err, out_valid
  );
endinterface

// File: rtl/leb128_i64_stream_dec.sv
// Signed LEB128 byte stream to 64-bit value decoder.
// 10-byte window feeds one combinational unpacker.
module unpack_i64 (
  input  logic [79:0] b,
  output logic [63:0] o,
  output logic [3:0]  len
);
  logic [63:0] acc;
  logic        done;

  always_comb begin
    acc  = '0;
    done = 1'b0;
    len  = 4'd10;
    for (int i = 0; i < 10; i++) begin
      if (!done) begin
        acc = acc | ({57'd0, b[8*i +: 7]} << (7*i));
        if (!b[8*i+7]) begin
          done = 1'b1;
          len  = 4'(i + 1);
          // sign bit of the last group fills every bit above it
          if (b[8*i+6])
            acc = acc | (~64'd0 << (7*i + 7));
        end
      end
    end
    o = acc;
  end
endmodule

module leb128_i64_stream_dec #(
  parameter int MAXB = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  leb128_i64_stream_dec_if.slave bus
);
  logic [7:0]        win   [MAXB];
  logic [7:0]        win_n [MAXB];
  logic [3:0]        cnt;
  logic [3:0]        cnt_n;
  logic [8*MAXB-1:0] vec;
  logic [63:0]       uo;
  logic [3:0]        ulen;
  logic              term;
  logic              full;
  logic              fire;
  logic              acc;
  logic [3:0]        cons;
  logic [3:0]        wr;
  logic [63:0]       odata;
  logic [3:0]        olen;
  logic              oerr;
  logic              ovalid;

  // bytes past cnt are presented as 0x00
  always_comb begin
    vec  = '0;
    term = 1'b0;
    for (int i = 0; i < MAXB; i++) begin
      if (4'(i) < cnt) begin
        vec[8*i +: 8] = win[i];
        if (!win[i][7]) term = 1'b1;
      end
    end
  end

  unpack_i64 u_unpack (
    .b   (vec),
    .o   (uo),
    .len (ulen)
  );

  assign full         = (cnt == 4'(MAXB));
  assign fire         = (term || full) && (!ovalid || bus.out_ready);
  assign bus.in_ready = rst_n && !flush && !full;
  assign acc          = bus.in_valid && bus.in_ready;
  assign cons         = fire ? (term ? ulen : 4'(MAXB)) : 4'd0;
  assign wr           = cnt - cons;
  assign cnt_n        = cnt - cons + {3'b000, acc};

  always_comb begin
    for (int i = 0; i < MAXB; i++) begin
      win_n[i] = 8'h00;
      for (int j = i; j < MAXB; j++) begin
        if (4'(j - i) == cons) win_n[i] = win[j];
      end
      if (acc && wr == 4'(i)) win_n[i] = bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      cnt    <= '0;
      ovalid <= 1'b0;
      odata  <= '0;
      olen   <= '0;
      oerr   <= 1'b0;
      for (int i = 0; i < MAXB; i++) win[i] <= 8'h00;
    end else begin
      cnt <= cnt_n;
      for (int i = 0; i < MAXB; i++) win[i] <= win_n[i];
      if (fire) begin
        ovalid <= 1'b1;
        odata  <= term ? uo : 64'd0;
        olen   <= cons;
        oerr   <= !term;
      end else if (bus.out_ready) begin
        ovalid <= 1'b0;
      end
    end
  end

  assign bus.out_data  = odata;
  assign bus.out_len   = olen;
  assign bus.out_err   = oerr;
  assign bus.out_valid = ovalid;
endmodule

// File: tb/tb_leb128_i64_stream_dec.sv
// Bench for leb128_i64_stream_dec: directed cases plus a
// randomized stream scored against an arithmetic LEB128 model.
module tb_leb128_i64_stream_dec;
  typedef struct {
    logic [63:0] d;
    logic [3:0]  l;
    logic        e;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  leb128_i64_stream_dec_if bus ();

  leb128_i64_stream_dec #(.MAXB(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  part [$];
  res_t        expq [$];
  logic [63:0] got_d [$];
  logic [3:0]  got_l [$];
  logic        got_e [$];
  bit          accepted;
  bit          rnd_rdy = 1'b0;
  bit          hold_p = 1'b0;
  logic [63:0] hold_d;
  logic [3:0]  hold_l;
  logic        hold_e;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, expv);
    end
  endtask

  // value = sum(group_i * 2^(7i)), minus 2^(7n) when the sign bit is set
  task automatic model_push(logic [7:0] b);
    res_t r;
    logic [127:0] v;
    part.push_back(b);
    if (!b[7] || part.size() == 10) begin
      v = '0;
      if (b[7]) begin
        r.d = '0;
        r.l = 4'd10;
        r.e = 1'b1;
      end else begin
        foreach (part[i]) v = v + ({121'd0, part[i][6:0]} << (7*i));
        if (b[6]) v = v - (128'd1 << (7*part.size()));
        r.d = v[63:0];
        r.l = 4'(part.size());
        r.e = 1'b0;
      end
      expq.push_back(r);
      part.delete();
    end
  endtask

  task automatic step();
    res_t r;
    if (rnd_rdy) bus.out_ready = ($urandom % 4) != 0;
    @(negedge clk);
    accepted = 1'b0;
    if (!rst_n || flush) begin
      part.delete();
      expq.delete();
      hold_p = 1'b0;
    end else begin
      if (hold_p) begin
        chk("hold_v", bus.out_valid, 1);
        chk("hold_d", bus.out_data, hold_d);
        chk("hold_l", bus.out_len, hold_l);
        chk("hold_e", bus.out_err, hold_e);
      end
      if (bus.in_valid && bus.in_ready) begin
        accepted = 1'b1;
        model_push(bus.in_data);
      end
      if (bus.out_valid && bus.out_ready) begin
        got_d.push_back(bus.out_data);
        got_l.push_back(bus.out_len);
        got_e.push_back(bus.out_err);
        if (expq.size() == 0) begin
          chk("spurious", bus.out_valid, 0);
        end else begin
          r = expq.pop_front();
          chk("sb_data", bus.out_data, r.d);
          chk("sb_len", bus.out_len, r.l);
          chk("sb_err", bus.out_err, r.e);
        end
      end
      hold_p = bus.out_valid && !bus.out_ready;
      hold_d = bus.out_data;
      hold_l = bus.out_len;
      hold_e = bus.out_err;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int t = 0; t < 200; t++) begin
      step();
      if (accepted) return;
    end
    chk("send_timeout", accepted, 1);
  endtask

  task automatic drain(int n);
    bus.in_valid = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int d;
    int len;
    int n0;
    int ncodes;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b1;
    repeat (3) step();
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_len", bus.out_len, 0);
    chk("rst_err", bus.out_err, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", bus.in_ready, 1);

    n = got_d.size();
    send(8'h01);
    bus.in_valid = 1'b0;
    step();
    chk("lat_early", got_d.size(), n);
    step();
    chk("lat_out", got_d.size(), n + 1);
    chk("one_cycle", bus.out_valid, 0);
    chk("b01_data", got_d[$], 64'd1);
    chk("b01_len", got_l[$], 1);
    chk("b01_err", got_e[$], 0);

    send(8'h7f);
    drain(3);
    chk("b7f_data", got_d[$], 64'hffff_ffff_ffff_ffff);
    chk("b7f_len", got_l[$], 1);

    repeat (9) send(8'hff);
    send(8'h01);
    drain(4);
    chk("max_data", got_d[$], 64'hffff_ffff_ffff_ffff);
    chk("max_len", got_l[$], 10);
    chk("max_left", expq.size() + part.size(), 0);

    repeat (4) send(8'h80);
    send(8'h0c);
    send(8'hbc);
    send(8'h0b);
    drain(5);
    chk("c5_data", got_d[$-1], 64'h0000_0000_c000_0000);
    chk("c5_len", got_l[$-1], 5);
    chk("c2_data", got_d[$], 64'h5bc);
    chk("c2_len", got_l[$], 2);

    got_d.delete();
    got_l.delete();
    got_e.delete();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    d = 0;
    repeat (15) begin
      bus.in_data = 8'(d);
      step();
      if (accepted) d++;
    end
    chk("bp_accepted", d, 11);
    chk("bp_in_ready", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    drain(20);
    chk("bp_count", got_d.size(), 11);
    for (int i = 0; i < 11 && i < got_d.size(); i++)
      chk("bp_order", got_d[i], i);

    repeat (10) send(8'h80);
    send(8'h05);
    drain(5);
    chk("err_flag", got_e[$-1], 1);
    chk("err_len", got_l[$-1], 10);
    chk("err_data", got_d[$-1], 0);
    chk("after_err", got_d[$], 5);

    n = got_d.size();
    send(8'h80);
    send(8'h80);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    send(8'h03);
    drain(4);
    chk("rst_mid_cnt", got_d.size(), n + 1);
    chk("rst_mid_data", got_d[$], 3);
    chk("rst_mid_len", got_l[$], 1);

    n = got_d.size();
    send(8'h80);
    send(8'h80);
    bus.in_valid = 1'b0;
    flush = 1'b1;
    #1;
    chk("flush_in_ready", bus.in_ready, 0);
    step();
    flush = 1'b0;
    send(8'h03);
    drain(4);
    chk("fl_mid_cnt", got_d.size(), n + 1);
    chk("fl_mid_data", got_d[$], 3);
    chk("fl_mid_len", got_l[$], 1);

    n0 = got_d.size();
    ncodes = 300;
    rnd_rdy = 1'b1;
    for (int c = 0; c < ncodes; c++) begin
      if (($urandom % 16) == 0) begin
        repeat (10) send(8'($urandom) | 8'h80);
      end else begin
        len = $urandom_range(1, 10);
        for (int i = 0; i < len; i++) begin
          if (($urandom % 4) == 0) begin
            bus.in_valid = 1'b0;
            step();
          end
          if (i == len - 1) send(8'($urandom) & 8'h7f);
          else send(8'($urandom) | 8'h80);
        end
      end
    end
    rnd_rdy = 1'b0;
    bus.out_ready = 1'b1;
    drain(30);
    chk("rnd_count", got_d.size() - n0, ncodes);
    chk("rnd_left", expq.size() + part.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
